battle_sequencer: RTL and testbench

Turn-level controller for the battle screen. It drives the phase code and pattern index into the enemy attack block, and consumes that block's finished and damage pulses. It owns player and enemy hit points, runs a damage-invulnerability window, and decides win/lose. It sits between the player menu/input logic and the enemy attack block, and feeds the HUD and top-level display mux.

---
 rtl/battle_sequencer.sv | 168 ++++++++++++++++
 tb/tb_battle_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/battle_sequencer.sv
// Turn-level battle controller: phase code, turn index, player/enemy HP, hit invulnerability.
// Optional enemy-phase watchdog is built only when BATTLE_WATCHDOG_EN is defined.
module battle_sequencer #(
   parameter int unsigned PLAYER_HP_MAX  = 20,
   parameter int unsigned ENEMY_HP_MAX   = 30,
   parameter int unsigned ATTACK_DMG     = 5,
   parameter int unsigned HEAL_AMT       = 6,
   parameter int unsigned ARROW_DMG      = 4,
   parameter int unsigned NUM_TURNS      = 10,
   parameter int unsigned INVULN_CYCLES  = 32_500_000,
   parameter int unsigned TIMEOUT_CYCLES = 1_950_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_in,
   input  logic       action_valid_in,
   input  logic [1:0] action_in,
   input  logic       enemy_finished_in,
   input  logic       damage_in,
   output logic [3:0] state_out,
   output logic [3:0] turn_out,
   output logic [7:0] player_hp_out,
   output logic [7:0] enemy_hp_out,
   output logic       hit_flash_out
);

   typedef enum logic [3:0] {
      ST_IDLE   = 4'b0000,
      ST_PLAYER = 4'b0001,
      ST_ENEMY  = 4'b1000,
      ST_WIN    = 4'b1100,
      ST_LOSE   = 4'b1111
   } state_t;

   localparam logic [7:0]  P_MAX       = 8'(PLAYER_HP_MAX);
   localparam logic [7:0]  E_MAX       = 8'(ENEMY_HP_MAX);
   localparam logic [7:0]  ATK         = 8'(ATTACK_DMG);
   localparam logic [8:0]  HEAL        = 9'(HEAL_AMT);
   localparam logic [7:0]  ARROW       = 8'(ARROW_DMG);
   localparam logic [3:0]  TURN_LAST   = 4'(NUM_TURNS - 1);
   localparam logic [31:0] INVULN_LOAD = 32'(INVULN_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  turn_q, turn_d;
   logic [7:0]  php_q, php_d;
   logic [7:0]  ehp_q, ehp_d;
   logic [31:0] inv_q, inv_d;
   logic        flash_q, flash_d;
   logic        hit_s;
   logic        init_s;
   logic        finish_s;
   logic [8:0]  heal_sum_s;

`ifdef BATTLE_WATCHDOG_EN
   localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] wd_q, wd_d;
`endif

   always_comb begin
      state_d    = state_q;
      turn_d     = turn_q;
      php_d      = php_q;
      ehp_d      = ehp_q;
      inv_d      = (inv_q != 32'd0) ? (inv_q - 32'd1) : 32'd0;
      hit_s      = 1'b0;
      init_s     = 1'b0;
      finish_s   = enemy_finished_in;
      heal_sum_s = {1'b0, php_q} + HEAL;
`ifdef BATTLE_WATCHDOG_EN
      // A timeout coinciding with a real finish still counts as one finish.
      if (wd_q == WD_LAST) begin
         finish_s = 1'b1;
      end else begin
         finish_s = enemy_finished_in;
      end
`endif

      case (state_q)
         ST_IDLE, ST_WIN, ST_LOSE: begin
            if (start_in) begin
               init_s  = 1'b1;
               state_d = ST_PLAYER;
               turn_d  = 4'd0;
               php_d   = P_MAX;
               ehp_d   = E_MAX;
               inv_d   = 32'd0;
            end else begin
               state_d = state_q;
            end
         end
         ST_PLAYER: begin
            if (action_valid_in) begin
               case (action_in)
                  2'b00:   ehp_d = (ehp_q >= ATK) ? (ehp_q - ATK) : 8'd0;
                  2'b01:   php_d = (heal_sum_s > {1'b0, P_MAX}) ? P_MAX : heal_sum_s[7:0];
                  default: ehp_d = ehp_q;
               endcase
               state_d = (ehp_d == 8'd0) ? ST_WIN : ST_ENEMY;
            end else begin
               state_d = ST_PLAYER;
            end
         end
         ST_ENEMY: begin
            if (damage_in && (inv_q == 32'd0)) begin
               hit_s = 1'b1;
               php_d = (php_q >= ARROW) ? (php_q - ARROW) : 8'd0;
               inv_d = INVULN_LOAD;
            end else begin
               hit_s = 1'b0;
            end
            // Damage is resolved before the finish pulse: a lethal hit suppresses the turn advance.
            if (hit_s && (php_d == 8'd0)) begin
               state_d = ST_LOSE;
            end else if (finish_s) begin
               state_d = ST_PLAYER;
               turn_d  = (turn_q == TURN_LAST) ? 4'd0 : (turn_q + 4'd1);
            end else begin
               state_d = ST_ENEMY;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The flag spans the load cycle plus the full countdown.
      flash_d = (hit_s || (inv_q != 32'd0)) && !init_s;

`ifdef BATTLE_WATCHDOG_EN
      wd_d = ((state_q == ST_ENEMY) && (state_d == ST_ENEMY)) ? (wd_q + 32'd1) : 32'd0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         turn_q  <= 4'd0;
         php_q   <= P_MAX;
         ehp_q   <= E_MAX;
         inv_q   <= 32'd0;
         flash_q <= 1'b0;
      end else begin
         state_q <= state_d;
         turn_q  <= turn_d;
         php_q   <= php_d;
         ehp_q   <= ehp_d;
         inv_q   <= inv_d;
         flash_q <= flash_d;
      end
   end

`ifdef BATTLE_WATCHDOG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q <= 32'd0;
      end else begin
         wd_q <= wd_d;
      end
   end
`endif

   assign state_out     = state_q;
   assign turn_out      = turn_q;
   assign player_hp_out = php_q;
   assign enemy_hp_out  = ehp_q;
   assign hit_flash_out = flash_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// Randomized bench for battle_sequencer checked against an event-level battle model.
module tb_battle_sequencer;

   localparam int INV  = 100;
   localparam int TOUT = 50;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_in = 1'b0;
   logic       action_valid_in = 1'b0;
   logic [1:0] action_in = 2'b00;
   logic       enemy_finished_in = 1'b0;
   logic       damage_in = 1'b0;
   logic [3:0] state_out;
   logic [3:0] turn_out;
   logic [7:0] player_hp_out;
   logic [7:0] enemy_hp_out;
   logic       hit_flash_out;

   int tests_run = 0;
   int tests_failed = 0;

   battle_sequencer #(
      .INVULN_CYCLES  (INV),
      .TIMEOUT_CYCLES (TOUT)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start_in          (start_in),
      .action_valid_in   (action_valid_in),
      .action_in         (action_in),
      .enemy_finished_in (enemy_finished_in),
      .damage_in         (damage_in),
      .state_out         (state_out),
      .turn_out          (turn_out),
      .player_hp_out     (player_hp_out),
      .enemy_hp_out      (enemy_hp_out),
      .hit_flash_out     (hit_flash_out)
   );

   always #5 clk = ~clk;

   // Model: game phase, HP values, turn, and the edge index of the last accepted hit.
   localparam logic [3:0] M_IDLE = 4'b0000, M_PLAYER = 4'b0001, M_ENEMY = 4'b1000,
                          M_WIN = 4'b1100, M_LOSE = 4'b1111;
   logic [3:0] m_state = M_IDLE;
   int    m_php = 20, m_ehp = 30, m_turn = 0;
   bit    m_hit_valid = 1'b0;
   longint m_hit_at = 0, m_entry = 0, n = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d at edge %0d", tag, got, exp, n);
      end
   endtask

   task automatic model_edge(input bit s, input bit av, input logic [1:0] a,
                             input bit ef, input bit dm, input bit r);
      bit fin;
      n++;
      if (r) begin
         m_state = M_IDLE; m_php = 20; m_ehp = 30; m_turn = 0; m_hit_valid = 1'b0;
      end else if (m_state == M_IDLE || m_state == M_WIN || m_state == M_LOSE) begin
         if (s) begin
            m_state = M_PLAYER; m_php = 20; m_ehp = 30; m_turn = 0; m_hit_valid = 1'b0;
         end
      end else if (m_state == M_PLAYER) begin
         if (av) begin
            if (a == 2'b00) m_ehp = (m_ehp > 5) ? m_ehp - 5 : 0;
            else if (a == 2'b01) m_php = (m_php + 6 > 20) ? 20 : m_php + 6;
            if (m_ehp == 0) m_state = M_WIN;
            else begin
               m_state = M_ENEMY;
               m_entry = n;
            end
         end
      end else begin
         fin = ef;
`ifdef BATTLE_WATCHDOG_EN
         if (n - m_entry == TOUT) fin = 1'b1;
`endif
         if (dm && (!m_hit_valid || (n - m_hit_at >= INV))) begin
            m_php = (m_php > 4) ? m_php - 4 : 0;
            m_hit_valid = 1'b1;
            m_hit_at = n;
         end
         if (m_php == 0) m_state = M_LOSE;
         else if (fin) begin
            m_state = M_PLAYER;
            m_turn = (m_turn + 1) % 10;
         end
      end
   endtask

   task automatic step(input bit s, input bit av, input logic [1:0] a,
                       input bit ef, input bit dm, input bit r);
      @(negedge clk);
      rst = r; start_in = s; action_valid_in = av; action_in = a;
      enemy_finished_in = ef; damage_in = dm;
      @(posedge clk);
      model_edge(s, av, a, ef, dm, r);
      #1;
      check_eq("state", 32'(state_out), 32'(m_state));
      check_eq("turn", 32'(turn_out), 32'(m_turn));
      check_eq("player_hp", 32'(player_hp_out), 32'(m_php));
      check_eq("enemy_hp", 32'(enemy_hp_out), 32'(m_ehp));
      check_eq("hit_flash", 32'(hit_flash_out),
               32'(m_hit_valid && (n - m_hit_at < INV)));
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(0, 0, 2'b00, 0, 0, 0);
   endtask

   task automatic act(input logic [1:0] a);
      step(0, 1, a, 0, 0, 0);
   endtask

   bit         rs, ss, avs, efs, dms;
   logic [1:0] as;

   initial begin
      step(0, 0, 2'b00, 0, 0, 1);
      step(0, 0, 2'b00, 0, 0, 1);
      idle(2);
      step(1, 0, 2'b00, 0, 0, 0);
      // Six attacks with finishes in between; the last one wins.
      for (int i = 0; i < 6; i++) begin
         act(2'b00);
         idle(2);
         step(0, 0, 2'b00, 1, 0, 0);
      end
      check_eq("win_turn", 32'(turn_out), 32'd5);
      check_eq("win_state", 32'(state_out), 32'(4'b1100));
      // Invulnerability window: second pulse dropped, third accepted.
      step(1, 1, 2'b00, 0, 0, 0);
      act(2'b10);
      step(0, 0, 2'b00, 0, 1, 0);
      idle(9);
      step(0, 0, 2'b00, 0, 1, 0);
      idle(109);
      step(0, 0, 2'b00, 0, 1, 0);
      check_eq("third_hit_hp", 32'(player_hp_out), 32'd12);
      step(0, 0, 2'b00, 1, 0, 0);
      // Heal 12 -> 18, then heal 18 -> 20 saturates.
      act(2'b01);
      step(0, 0, 2'b00, 1, 0, 0);
      act(2'b01);
      check_eq("heal_sat", 32'(player_hp_out), 32'd20);
      step(0, 0, 2'b00, 1, 0, 0);
      // Bring HP to 4, then lethal hit together with finish.
      for (int i = 0; i < 4; i++) begin
         act(2'b10);
         idle(INV);
         step(0, 0, 2'b00, 0, 1, 0);
         step(0, 0, 2'b00, 1, 0, 0);
      end
      act(2'b10);
      idle(INV);
      step(0, 0, 2'b00, 1, 1, 0);
      // Ten full turns to exercise the wrap.
      step(1, 0, 2'b00, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         act(2'b11);
         step(0, 0, 2'b00, 1, 0, 0);
      end
      check_eq("turn_wrap", 32'(turn_out), 32'd0);
      // Watchdog-sensitive stretch: sit in ENEMY with no finish.
      act(2'b10);
      idle(60);
      step(0, 0, 2'b00, 0, 0, 1);
      step(1, 0, 2'b00, 0, 0, 0);
      for (int i = 0; i < 15000; i++) begin
         rs  = ($urandom_range(0, 999) == 0);
         ss  = (m_state == M_IDLE || m_state == M_WIN || m_state == M_LOSE) ?
               ($urandom_range(0, 9) == 0) : ($urandom_range(0, 49) == 0);
         avs = ($urandom_range(0, 3) == 0);
         as  = 2'($urandom_range(0, 3));
         efs = ($urandom_range(0, 29) == 0);
         dms = ($urandom_range(0, 14) == 0);
         step(ss, avs, as, efs, dms, rs);
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
